// File: rtl/sevenseg_pkg.sv
// Shared glyph constants, slot type and output polarity helpers for the scan driver.
// Glyphs are held active-high in {g,f,e,d,c,b,a} order; polarity is applied at the pins.
package sevenseg_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    function automatic logic [6:0] seg_pol(input logic [6:0] v, input logic active_low);
        return active_low ? ~v : v;
    endfunction

    function automatic logic [3:0] an_pol(input logic [3:0] v, input logic active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder, active-high {g,f,e,d,c,b,a}.
// Codes 0xA-0xF show a dash so bad counter values are visible on the display.
module bcd_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-frame input snapshot,
// anti-ghosting guard at the start of each slot and optional leading-zero blanking.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       r,
    input  logic       en,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int            PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST_CNT = PW'(REFRESH_DIV - 1);
    localparam logic          POL      = (ACTIVE_LOW != 0);

    logic [PW-1:0]   r_presc;
    slot_t           r_slot;
    logic [3:0][3:0] r_snap_dig;
    logic [3:0]      r_snap_dpm;
    logic            r_snap_blz;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;

    logic            w_wrap;
    logic            w_frame_end;
    logic            w_guard_done;
    logic            w_lz_blank;
    logic            w_lit;
    logic [3:0]      w_digit;
    logic [6:0]      w_glyph;

    assign w_wrap      = (r_presc == LAST_CNT);
    assign w_frame_end = w_wrap && (r_slot == 2'd3);

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_presc <= '0;
            r_slot  <= 2'd0;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_slot  <= r_slot + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Inputs are only sampled at the frame boundary so a frame never mixes old and new values.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_snap_dig <= '0;
            r_snap_dpm <= '0;
            r_snap_blz <= 1'b0;
        end else if (w_frame_end) begin
            r_snap_dig <= {digit3, digit2, digit1, digit0};
            r_snap_dpm <= dp_mask;
            r_snap_blz <= blank_lz;
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign w_guard_done = 1'b1;
        end else begin : g_guard
            assign w_guard_done = (r_presc >= PW'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        w_lz_blank = 1'b0;
        case (r_slot)
            2'd3:    w_lz_blank = (r_snap_dig[3] == 4'd0);
            2'd2:    w_lz_blank = (r_snap_dig[3] == 4'd0) && (r_snap_dig[2] == 4'd0);
            2'd1:    w_lz_blank = (r_snap_dig[3] == 4'd0) && (r_snap_dig[2] == 4'd0)
                                  && (r_snap_dig[1] == 4'd0);
            default: w_lz_blank = 1'b0;
        endcase
        w_lz_blank = w_lz_blank & r_snap_blz;
    end

    assign w_digit = r_snap_dig[r_slot];
    assign w_lit   = w_guard_done && en && !w_lz_blank;

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_glyph)
    );

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_an  <= an_pol(4'b0000, POL);
            r_seg <= seg_pol(SEG_OFF, POL);
            r_dp  <= POL;
        end else begin
            r_an  <= an_pol(w_lit ? (4'b0001 << r_slot) : 4'b0000, POL);
            r_seg <= seg_pol(w_lit ? w_glyph : SEG_OFF, POL);
            r_dp  <= POL ^ (w_lit & r_snap_dpm[r_slot]);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for the scan driver at REFRESH_DIV=8, BLANK_CYCLES=2, active-low outputs.
// A cycle-count reference model predicts every output; directed scenarios add explicit checks.
module tb_sevenseg_scan_driver;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * DIV;

    // Active-low glyphs indexed by digit value.
    localparam logic [6:0] GLY_AL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic       clk = 1'b0;
    logic       r   = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] d_in [4];
    logic [3:0] dpm_in = 4'd0;
    logic       blz_in = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycles since reset plus the captured frame image.
    int         cyc;
    logic [3:0] m_dig [4];
    logic [3:0] m_dpm;
    logic       m_blz;

    // Per-frame observation summary.
    int         cnt_on [4];
    logic [6:0] first_seg [4];
    int         dp_low_cnt;
    int         dp_low_other;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (GUARD),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk      (clk),
        .r        (r),
        .en       (en),
        .digit0   (d_in[0]),
        .digit1   (d_in[1]),
        .digit2   (d_in[2]),
        .digit3   (d_in[3]),
        .dp_mask  (dpm_in),
        .blank_lz (blz_in),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
        end
    endtask

    function automatic logic [11:0] model_out(input logic e);
        int   p = cyc % DIV;
        int   s = (cyc / DIV) % 4;
        logic lz = 1'b0;
        logic lit;
        if (m_blz && s > 0) begin
            lz = 1'b1;
            for (int k = s; k < 4; k++)
                if (m_dig[k] != 4'd0) lz = 1'b0;
        end
        lit = (p >= GUARD) && e && !lz;
        if (lit)
            return {~(4'b0001 << s), GLY_AL[m_dig[s]], ~m_dpm[s]};
        return {4'b1111, 7'b1111111, 1'b1};
    endfunction

    task automatic model_clear();
        cyc = 0;
        for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
        m_dpm = 4'd0;
        m_blz = 1'b0;
    endtask

    // One clock: inputs are stable here, the model follows the same edge, outputs checked at negedge.
    task automatic tick();
        logic [11:0] exp;
        @(posedge clk);
        exp = model_out(en);
        if (cyc % FRAME == FRAME - 1) begin
            for (int k = 0; k < 4; k++) m_dig[k] = d_in[k];
            m_dpm = dpm_in;
            m_blz = blz_in;
        end
        cyc++;
        @(negedge clk);
        check_val("an",  {28'd0, an},  {28'd0, exp[11:8]});
        check_val("seg", {25'd0, seg}, {25'd0, exp[7:1]});
        check_val("dp",  {31'd0, dp},  {31'd0, exp[0]});
    endtask

    task automatic to_frame();
        tick();
        while (cyc % FRAME != 0) tick();
    endtask

    task automatic observe_frame();
        for (int k = 0; k < 4; k++) begin
            cnt_on[k]    = 0;
            first_seg[k] = 7'h00;
        end
        dp_low_cnt   = 0;
        dp_low_other = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            for (int k = 0; k < 4; k++)
                if (an[k] == 1'b0) begin
                    if (cnt_on[k] == 0) first_seg[k] = seg;
                    cnt_on[k]++;
                end
            if (dp == 1'b0) begin
                dp_low_cnt++;
                if (an != 4'b1011) dp_low_other++;
            end
        end
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        d_in[3] = d3; d_in[2] = d2; d_in[1] = d1; d_in[0] = d0;
    endtask

    task automatic mid_reset();
        r = 1'b1;
        #1;
        check_val("rst_mid_an",  {28'd0, an},  32'hF);
        check_val("rst_mid_seg", {25'd0, seg}, 32'h7F);
        check_val("rst_mid_dp",  {31'd0, dp},  32'h1);
        @(negedge clk);
        check_val("rst_hold_an", {28'd0, an}, 32'hF);
        r = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [6:0] seen;
        model_clear();
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            dpm_in = 4'($urandom);
            blz_in = 1'($urandom);
            en     = 1'($urandom);
            @(negedge clk);
            check_val("rst_an",  {28'd0, an},  32'hF);
            check_val("rst_seg", {25'd0, seg}, 32'h7F);
            check_val("rst_dp",  {31'd0, dp},  32'h1);
        end
        r = 1'b0;
        model_clear();

        // Basic digit display, first frame shows the all-zero reset image.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        dpm_in = 4'd0;
        blz_in = 1'b0;
        en     = 1'b1;
        to_frame();
        observe_frame();
        for (int k = 0; k < 4; k++) check_val("on_cnt", cnt_on[k], 6);
        check_val("seg_slot0", {25'd0, first_seg[0]}, {25'd0, 7'b0011001});
        check_val("seg_slot3", {25'd0, first_seg[3]}, {25'd0, 7'b1111001});

        // Leading-zero blanking.
        blz_in = 1'b1;
        set_digits(4'd0, 4'd0, 4'd0, 4'd7);
        to_frame();
        observe_frame();
        check_val("lz7_on0", cnt_on[0], 6);
        check_val("lz7_off", cnt_on[1] + cnt_on[2] + cnt_on[3], 0);
        check_val("lz7_seg", {25'd0, first_seg[0]}, {25'd0, 7'b1111000});
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        to_frame();
        observe_frame();
        check_val("lz0_on0", cnt_on[0], 6);
        check_val("lz0_off", cnt_on[1] + cnt_on[2] + cnt_on[3], 0);
        check_val("lz0_seg", {25'd0, first_seg[0]}, {25'd0, 7'b1000000});
        set_digits(4'd0, 4'd5, 4'd0, 4'd0);
        to_frame();
        observe_frame();
        check_val("lz5_on3", cnt_on[3], 0);
        check_val("lz5_on2", cnt_on[2], 6);
        check_val("lz5_on1", cnt_on[1], 6);

        // Tearing: digit2 changes mid-frame.
        blz_in = 1'b0;
        set_digits(4'd1, 4'd3, 4'd3, 4'd4);
        to_frame();
        while (cyc % FRAME != DIV + 4) tick();
        d_in[2] = 4'd9;
        seen = 7'h00;
        while (cyc % FRAME != 0) begin
            tick();
            if (an == 4'b1011) seen = seg;
        end
        check_val("tear_old", {25'd0, seen}, {25'd0, 7'b0110000});
        observe_frame();
        check_val("tear_new", {25'd0, first_seg[2]}, {25'd0, 7'b0010000});

        // Error glyph and decimal point.
        set_digits(4'd1, 4'd2, 4'hB, 4'd4);
        dpm_in = 4'b0100;
        to_frame();
        observe_frame();
        check_val("dash_seg",    {25'd0, first_seg[1]}, {25'd0, 7'b0111111});
        check_val("dp_low_cnt",  dp_low_cnt, 6);
        check_val("dp_low_else", dp_low_other, 0);

        // Enable off, then back on mid-slot.
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("en0_an", {28'd0, an}, 32'hF);
        end
        while (cyc % FRAME != 2 * DIV + 5) tick();
        en = 1'b1;
        tick();
        check_val("en1_an", {28'd0, an}, {28'd0, 4'b1011});

        // Reset in the middle of a slot.
        tick(); tick();
        @(posedge clk);
        #2;
        mid_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 4; k++)
                    d_in[k] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
                dpm_in = 4'($urandom);
                blz_in = 1'($urandom);
            end
            if ($urandom_range(0, 15) == 0) en = ~en;
            if (i == 20 * FRAME + 13) mid_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
